// File: rtl/ws2812_frame_ctl.sv
// Frame sequencer that fetches pixel words from a synchronous RAM and feeds a WS2812 bit serializer.
// Optional WS2812_GRB_ORDER_EN: reorder stored {R,G,B} words to {G,R,B} on the wire.
module ws2812_frame_ctl #(
    parameter int ADDR_W = 8,
    parameter int PIX_W  = 24
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              frame_start_in,
    input  logic [ADDR_W:0]   led_num_in,
    input  logic [15:0]       rst_cnt_in,
    output logic              ram_rd_en_out,
    output logic [ADDR_W-1:0] ram_rd_addr_out,
    input  logic [PIX_W-1:0]  ram_rd_data_in,
    output logic              bit_rdy_out,
    output logic              bit_data_out,
    input  logic              bit_done_in,
    output logic              busy_out,
    output logic              frame_done_out
);

    localparam int CNT_W = $clog2(PIX_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_LATCH,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W:0]   r_led_num;
    logic [15:0]       r_rst_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [PIX_W-1:0]  r_shreg;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [15:0]       r_latch_cnt;

    logic              r_rd_en;
    logic              r_bit_rdy;
    logic              r_bit_data;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_rd_en_nxt;
    logic              w_bit_rdy_nxt;
    logic              w_bit_data_nxt;
    logic              w_busy_nxt;
    logic              w_frame_done_nxt;

    logic              w_last_bit;
    logic              w_last_pix;
    logic              w_latch_end;
    logic [PIX_W-1:0]  w_pix_word;

    // A gap length of zero still costs one LATCH cycle, so the counter is loaded with len-1 floored at 0.
    function automatic logic [15:0] latchLoad(input logic [15:0] len);
        return (len == 16'd0) ? 16'd0 : len - 16'd1;
    endfunction

`ifdef WS2812_GRB_ORDER_EN
    assign w_pix_word = {ram_rd_data_in[15:8], ram_rd_data_in[23:16], ram_rd_data_in[7:0]};
`else
    assign w_pix_word = ram_rd_data_in;
`endif

    assign w_last_bit  = (r_bit_cnt == '0);
    assign w_last_pix  = (({1'b0, r_addr} + (ADDR_W+1)'(1)) == r_led_num);
    assign w_latch_end = (r_latch_cnt == 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start_in) begin
                    w_state_nxt = (led_num_in == '0) ? S_LATCH : S_FETCH;
                end
            end
            S_FETCH: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SEND;
            S_SEND: begin
                if (bit_done_in && w_last_bit) begin
                    w_state_nxt = w_last_pix ? S_LATCH : S_FETCH;
                end
            end
            S_LATCH: begin
                if (w_latch_end) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, so every output is a flop driven one edge ahead.
    always_comb begin
        w_rd_en_nxt      = (w_state_nxt == S_FETCH);
        w_busy_nxt       = (w_state_nxt != S_IDLE);
        w_frame_done_nxt = (w_state_nxt == S_DONE);
        w_bit_rdy_nxt    = 1'b0;
        w_bit_data_nxt   = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_bit_rdy_nxt  = 1'b1;
                w_bit_data_nxt = r_shreg[PIX_W-1];
            end
            S_SEND: begin
                if (bit_done_in) begin
                    w_bit_rdy_nxt  = !w_last_bit;
                    w_bit_data_nxt = w_last_bit ? 1'b0 : r_shreg[PIX_W-2];
                end else begin
                    w_bit_data_nxt = r_bit_data;
                end
            end
            default: begin
                w_bit_rdy_nxt  = 1'b0;
                w_bit_data_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state      <= S_IDLE;
            r_rd_en      <= 1'b0;
            r_bit_rdy    <= 1'b0;
            r_bit_data   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_en      <= w_rd_en_nxt;
            r_bit_rdy    <= w_bit_rdy_nxt;
            r_bit_data   <= w_bit_data_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    // The RAM word is only guaranteed during WAIT, so it is captured there; LOAD then arms the bit counter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_led_num   <= '0;
            r_rst_cnt   <= 16'd0;
            r_addr      <= '0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_latch_cnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (frame_start_in) begin
                        r_led_num   <= led_num_in;
                        r_rst_cnt   <= rst_cnt_in;
                        r_addr      <= '0;
                        r_latch_cnt <= latchLoad(rst_cnt_in);
                    end
                end
                S_WAIT: begin
                    r_shreg <= w_pix_word;
                end
                S_LOAD: begin
                    r_bit_cnt <= CNT_W'(PIX_W-1);
                end
                S_SEND: begin
                    if (bit_done_in) begin
                        if (!w_last_bit) begin
                            r_shreg   <= {r_shreg[PIX_W-2:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - CNT_W'(1);
                        end else if (!w_last_pix) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end else begin
                            r_latch_cnt <= latchLoad(r_rst_cnt);
                        end
                    end
                end
                S_LATCH: begin
                    if (!w_latch_end) begin
                        r_latch_cnt <= r_latch_cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    r_addr <= '0;
                end
                default: begin
                    r_addr <= r_addr;
                end
            endcase
        end
    end

    assign ram_rd_en_out   = r_rd_en;
    assign ram_rd_addr_out = r_addr;
    assign bit_rdy_out     = r_bit_rdy;
    assign bit_data_out    = r_bit_data;
    assign busy_out        = r_busy;
    assign frame_done_out  = r_frame_done;

endmodule
